// File: rtl/uart_tx_mmio_responder.sv
// uart_tx_mmio_responder: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Word reads are combinational; strobed byte writes land on clk_i.
// Optional parity: define UART_TX_PARITY_EN to make CTRL bits 2-3
// (parity_en, parity_odd) writable and insert a parity bit before STOP.
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a queued byte
// START  | start bit, line low for DIV+1 cycles
// DATA   | eight data bits, LSB first, DIV+1 cycles each
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit, line high; may chain straight into the next START
module uart_tx_mmio_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] address_i,
  input  logic        write_enable_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_data_strobe_i,
  output logic [31:0] read_data_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [15:0]    divisor_q, div_lat_q, cnt_q;
  logic [3:0]     ctrl_q;
  logic           ovf_q;
  logic [7:0]     shift_q;
  logic [2:0]     idx_q;
`ifdef UART_TX_PARITY_EN
  logic           par_en_q, par_bit_q;
`endif

  logic hit, wr, wr_txdata, push, pop, full, empty, busy, bit_done;
  logic tx_en, irq_en, ovf_set, ovf_clr;
  logic [1:0] offset;
  logic unused_bits;

  assign hit       = (address_i[31:4] == BASE_ADDR[31:4]);
  assign offset    = address_i[3:2];
  assign wr        = hit & write_enable_i;
  assign wr_txdata = wr & (offset == 2'd0) & write_data_strobe_i[0];
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign tx_en     = ctrl_q[0];
  assign irq_en    = ctrl_q[1];
  assign bit_done  = (cnt_q == '0);
  // A push into a full FIFO is still accepted when the head leaves that cycle.
  assign push      = wr_txdata & (~full | pop);
  assign ovf_set   = wr_txdata & full & ~pop;
  assign ovf_clr   = wr & (offset == 2'd1) & write_data_strobe_i[0] & write_data_i[3];
  assign irq_o     = irq_en & empty & ~busy;
  assign unused_bits = ^{address_i[1:0], write_data_i[31:16]};

  // Configuration registers and the sticky overflow flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      divisor_q <= DEFAULT_DIV;
      ctrl_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (wr && offset == 2'd2) begin
        if (write_data_strobe_i[0]) divisor_q[7:0]  <= write_data_i[7:0];
        if (write_data_strobe_i[1]) divisor_q[15:8] <= write_data_i[15:8];
      end
      if (wr && offset == 2'd3 && write_data_strobe_i[0]) begin
        ctrl_q[1:0] <= write_data_i[1:0];
`ifdef UART_TX_PARITY_EN
        ctrl_q[3:2] <= write_data_i[3:2];
`endif
      end
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= write_data_i[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Serializer state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; pop marks a frame start (from IDLE or the last STOP cycle).
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_en && !empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA: begin
        if (bit_done && idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_d = S_STOP;
`endif
      S_STOP: begin
        if (bit_done) begin
          if (tx_en && !empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level and busy flag decoded from the registered state.
  always_comb begin
    tx_o = 1'b1;
    busy = 1'b1;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_o = par_bit_q;
`endif
      default:  tx_o = 1'b1;
    endcase
  end

  // Bit-period down-counter and shifter; divisor and parity setup latch per frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      div_lat_q <= DEFAULT_DIV;
      shift_q   <= '0;
      idx_q     <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (pop) begin
      cnt_q     <= divisor_q;
      div_lat_q <= divisor_q;
      shift_q   <= mem_q[rd_ptr_q];
      idx_q     <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= ctrl_q[2];
      par_bit_q <= (^mem_q[rd_ptr_q]) ^ ctrl_q[3];
`endif
    end else if (state_q != S_IDLE) begin
      if (bit_done) begin
        cnt_q <= div_lat_q;
        if (state_q == S_DATA) begin
          shift_q <= {1'b0, shift_q[7:1]};
          idx_q   <= idx_q + 3'd1;
        end
      end else begin
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  // Read mux; zero outside the window so responders can be ORed together.
  always_comb begin
    read_data_o = '0;
    if (hit) begin
      case (offset)
        2'd1:    read_data_o = {16'h0, 8'(count_q), 4'h0, ovf_q, busy, empty, full};
        2'd2:    read_data_o = {16'h0, divisor_q};
        2'd3:    read_data_o = {28'h0, ctrl_q};
        default: read_data_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio_responder.sv
// Bench for uart_tx_mmio_responder: register reads and serial frames are
// checked by two monitors against expectation queues filled by the stimulus.
module tb_uart_tx_mmio_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_CT = BASE + 32'hC;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] address_i = '0;
  logic        write_enable_i = 1'b0;
  logic [31:0] write_data_i = '0;
  logic [3:0]  write_data_strobe_i = '0;
  logic [31:0] read_data_o;
  logic        tx_o, irq_o;

  uart_tx_mmio_responder dut (
    .clk_i(clk_i), .reset_i(reset_i), .address_i(address_i),
    .write_enable_i(write_enable_i), .write_data_i(write_data_i),
    .write_data_strobe_i(write_data_strobe_i), .read_data_o(read_data_o),
    .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int cyc = 0, frames_done = 0, exp_frames = 0, b2b_seen = 0;
  int mon_div = 867;
  bit mon_en = 1'b1;
  bit rd_valid = 1'b0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [10:0] fr_exp_q[$];
  int          fr_n_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Read monitor: compares read data while the bench presents a read.
  always @(negedge clk_i) begin
    logic [31:0] e;
    string nm;
    #2;
    if (rd_valid) begin
      e  = rd_exp_q.pop_front();
      nm = rd_name_q.pop_front();
      checks++;
      if (read_data_o !== e) begin
        errors++;
        $display("FAIL rd_%s got 0x%08h exp 0x%08h", nm, read_data_o, e);
      end
    end
  end

  // Serial monitor: catches a start bit, samples every bit cycle, checks stability.
  initial begin
    logic [10:0] got, e;
    int p, n, last_end;
    bit stable, have_end, unexp;
    have_end = 1'b0;
    last_end = 0;
    forever begin
      @(posedge clk_i); #1;
      if (mon_en && !reset_i && tx_o === 1'b0) begin
        p = mon_div + 1;
        if (have_end && cyc == last_end + 1) b2b_seen++;
        unexp = (fr_n_q.size() == 0);
        if (unexp) begin
          n = 10;
          e = '0;
        end else begin
          n = fr_n_q.pop_front();
          e = fr_exp_q.pop_front();
        end
        got = '0;
        stable = 1'b1;
        for (int b = 0; b < n; b++) begin
          for (int c = 0; c < p; c++) begin
            if (b != 0 || c != 0) begin
              @(posedge clk_i); #1;
            end
            if (c == 0) got[b] = tx_o;
            else if (tx_o !== got[b]) stable = 1'b0;
          end
        end
        last_end = cyc;
        have_end = 1'b1;
        frames_done++;
        checks++;
        if (unexp) begin
          errors++;
          $display("FAIL tx_unexpected_frame got %b exp none", got);
        end else if (got !== e || !stable) begin
          errors++;
          $display("FAIL tx_frame got %b exp %b stable %0d", got, e, stable);
        end
      end
    end
  end

  task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", nm, act, e);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    address_i = a; write_data_i = d; write_data_strobe_i = s; write_enable_i = 1'b1;
    @(negedge clk_i);
    write_enable_i = 1'b0; write_data_strobe_i = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
    @(negedge clk_i);
    address_i = a;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(nm);
    rd_valid = 1'b1;
    #3;
    rd_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    fr_exp_q.push_back({1'b0, 1'b1, d, 1'b0});
    fr_n_q.push_back(10);
    exp_frames++;
    bus_write(A_TX, {24'h0, d}, 4'b0001);
  endtask

  task automatic wait_frames(input int budget, input string nm);
    int n = 0;
    while (frames_done < exp_frames && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (frames_done < exp_frames) begin
      errors++;
      $display("FAIL %s_timeout frames %0d exp %0d", nm, frames_done, exp_frames);
    end
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check1("reset_tx", {31'h0, tx_o}, 32'h1);
    reset_i = 1'b0;
    check1("reset_irq", {31'h0, irq_o}, 32'h0);
    bus_read(A_ST, 32'h2, "reset_status");
    bus_read(A_DV, 32'h363, "reset_div");
    bus_read(A_CT, 32'h0, "reset_ctrl");
    bus_read(A_TX, 32'h0, "txdata_reads_zero");

    // Decode and strobes.
    bus_read(BASE + 32'h20, 32'h0, "outside_window");
    bus_read(BASE + 32'h7, 32'h2, "status_low_bits_ignored");
    bus_write(A_TX, 32'h55, 4'b0010);
    bus_read(A_ST, 32'h2, "txdata_wrong_strobe");
    bus_write(A_DV, 32'hBEEF, 4'b0001);
    bus_read(A_DV, 32'h3EF, "div_byte0");
    bus_write(A_DV, 32'hFFFF_BEEF, 4'b0010);
    bus_read(A_DV, 32'hBEEF, "div_byte1");
    bus_write(A_CT, 32'hF, 4'b0001);
`ifdef UART_TX_PARITY_EN
    bus_read(A_CT, 32'hF, "ctrl_mask");
`else
    bus_read(A_CT, 32'h3, "ctrl_mask");
`endif
    check1("irq_idle_empty", {31'h0, irq_o}, 32'h1);
    bus_write(A_CT, 32'h0, 4'b0001);
    check1("irq_disabled", {31'h0, irq_o}, 32'h0);

    // Single frame 0xA5 at DIV=3.
    bus_write(A_DV, 32'h3, 4'b0011);
    mon_div = 3;
    bus_write(A_CT, 32'h1, 4'b0001);
    send(8'hA5);
    bus_read(A_ST, 32'h6, "single_busy_start");
    repeat (20) @(negedge clk_i);
    bus_read(A_ST, 32'h6, "single_busy_mid");
    wait_frames(100, "single");
    repeat (2) @(negedge clk_i);
    bus_read(A_ST, 32'h2, "single_done");
    check1("irq_before_en", {31'h0, irq_o}, 32'h0);
    bus_write(A_CT, 32'h3, 4'b0001);
    check1("irq_after_en", {31'h0, irq_o}, 32'h1);

    // Back-to-back frames at DIV=0.
    bus_write(A_CT, 32'h0, 4'b0001);
    bus_write(A_DV, 32'h0, 4'b0011);
    mon_div = 0;
    send(8'h01); send(8'h02); send(8'h03);
    bus_read(A_ST, 32'h300, "b2b_count3");
    b2b_seen = 0;
    bus_write(A_CT, 32'h1, 4'b0001);
    bus_read(A_ST, 32'h204, "b2b_count2");
    repeat (9) @(negedge clk_i);
    bus_read(A_ST, 32'h104, "b2b_count1");
    repeat (9) @(negedge clk_i);
    bus_read(A_ST, 32'h006, "b2b_count0");
    repeat (9) @(negedge clk_i);
    bus_read(A_ST, 32'h002, "b2b_idle");
    wait_frames(50, "b2b");
    check1("b2b_no_gap", b2b_seen, 32'd2);

    // Overflow with tx disabled.
    bus_write(A_CT, 32'h0, 4'b0001);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    bus_write(A_TX, 32'h18, 4'b0001);
    bus_read(A_ST, 32'h809, "ovf_full");
    bus_write(A_ST, 32'h8, 4'b0001);
    bus_read(A_ST, 32'h801, "ovf_cleared");
    bus_write(A_CT, 32'h1, 4'b0001);
    wait_frames(200, "ovf_drain");
    repeat (5) @(negedge clk_i);
    bus_read(A_ST, 32'h2, "ovf_drained");
    check1("ovf_9th_not_sent", frames_done, exp_frames);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has three ones, so even parity is 1 and odd parity is 0.
    bus_write(A_CT, 32'h0, 4'b0001);
    bus_write(A_DV, 32'h1, 4'b0011);
    mon_div = 1;
    bus_write(A_CT, 32'h5, 4'b0001);
    bus_read(A_CT, 32'h5, "parity_ctrl");
    fr_exp_q.push_back({1'b1, 1'b1, 8'h07, 1'b0});
    fr_n_q.push_back(11);
    exp_frames++;
    bus_write(A_TX, 32'h07, 4'b0001);
    wait_frames(60, "parity_even");
    bus_write(A_CT, 32'hD, 4'b0001);
    fr_exp_q.push_back({1'b1, 1'b0, 8'h07, 1'b0});
    fr_n_q.push_back(11);
    exp_frames++;
    bus_write(A_TX, 32'h07, 4'b0001);
    wait_frames(60, "parity_odd");
    repeat (3) @(negedge clk_i);
`endif

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    bus_write(A_DV, 32'h3, 4'b0011);
    bus_write(A_CT, 32'h1, 4'b0001);
    bus_write(A_TX, 32'h00, 4'b0001);
    repeat (8) @(negedge clk_i);
    check1("midframe_low", {31'h0, tx_o}, 32'h0);
    #1 reset_i = 1'b1;
    #1 check1("reset_tx_immediate", {31'h0, tx_o}, 32'h1);
    bus_read(A_ST, 32'h2, "rst_status");
    bus_read(A_DV, 32'h363, "rst_div");
    bus_read(A_CT, 32'h0, "rst_ctrl");
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check1("post_reset_tx", {31'h0, tx_o}, 32'h1);
    check1("post_reset_irq", {31'h0, irq_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio_responder.md
Name: uart_tx_mmio_responder

Overview:
- Memory-mapped UART transmitter on the core's data bus; the bus responder for the core's load/store initiator port.
- Responds to word reads with combinational read data, which fits the single-cycle load path. Responds to strobed byte writes on clk_i.
- Buffers bytes in a FIFO and serializes them as 8N1 on tx_o at a programmable bit period.
- Read data is zero outside the block's window, so the top level ORs it with the other responders.

Parameters:
- BASE_ADDR, 32'h1000_0000: base of the 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd867: reset value of DIVISOR. Bit period is DIVISOR+1 clk_i cycles.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset
- address_i  in  32  byte address from the core
- write_enable_i  in  1  store strobe from the core
- write_data_i  in  32  lane-aligned store data
- write_data_strobe_i  in  4  byte-lane enables
- read_data_o  out  32  combinational read data; 0 when address_i is outside the window
- tx_o  out  1  serial output; idles high
- irq_o  out  1  level interrupt

Behaviour:
- Reset: reset_i, asynchronous, active-high; clock clk_i.
  - tx_o=1, irq_o=0, FIFO empty, CTRL=0, overflow=0, DIVISOR=DEFAULT_DIV, FSM in IDLE.
  - Reset mid-frame aborts the frame; tx_o returns to 1 immediately.
- Address decode:
  - hit = (address_i[31:4] == BASE_ADDR[31:4]); offset = address_i[3:2].
  - address_i[1:0] is ignored.
  - Writes take effect on the rising clk_i edge when hit and write_enable_i are both 1.
- Register map:
  - 0x0 TXDATA
    - Write with strobe[0]=1 pushes write_data_i[7:0].
    - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set.
    - Reads return 0.
  - 0x4 STATUS (read-only except bit3)
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bits[15:8] FIFO count; other bits 0.
    - Writing 1 to bit3 with strobe[0]=1 clears overflow.
    - Overflow set and clear in the same cycle: set wins.
  - 0x8 DIVISOR
    - Bits[15:0], byte-writable through strobe[1:0]; bits[31:16] read 0.
  - 0xC CTRL
    - bit0 tx_en, bit1 irq_en; writable through strobe[0].
- FIFO:
  - Push and pop in the same cycle are both performed and count is unchanged; push is accepted even when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is $clog2(FIFO_DEPTH)+1.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx_o=1. If tx_en and the FIFO is not empty: pop the head byte into the shift register, latch DIVISOR into the bit-period counter, go to START on the next cycle.
  - START: tx_o=0 for DIV+1 cycles.
  - DATA: 8 bits, LSB first, each held DIV+1 cycles; a 3-bit index counts the bits.
  - STOP: tx_o=1 for DIV+1 cycles.
  - In the last STOP cycle, if tx_en and the FIFO is not empty: pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
  - A frame is 10*(DIV+1) cycles.
  - DIVISOR writes mid-frame take effect at the next frame start.
  - Clearing tx_en mid-frame lets the current frame complete; no further pops occur.
- irq_o = irq_en & empty & ~busy; combinational from registered state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - CTRL bit2 parity_en and bit3 parity_odd become writable.
  - When parity_en=1, a PARITY state lasting DIV+1 cycles is inserted between DATA and STOP.
  - The parity bit is the XOR of the 8 data bits, inverted when parity_odd=1.
  - The frame becomes 11*(DIV+1) cycles.
  - The parity configuration is latched at frame start.
- Not defined: CTRL bits 2-3 read 0 and ignore writes; no PARITY state exists.

Test Plan:
- Reset check: assert reset_i mid-frame -> tx_o=1 at once, STATUS reads 0x0000_0002, DIVISOR reads 0x363.
- Single frame: write DIVISOR=3, CTRL=1, TXDATA=0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy=1 throughout, then irq_o rises once irq_en is set.
- Back-to-back: write 3 bytes 0x01, 0x02, 0x03 at DIV=0 -> 30 consecutive frame cycles with no idle cycle between frames; count goes 3→2→1→0.
- Overflow: tx_en=0, push 9 bytes at FIFO_DEPTH=8 -> full=1, count=8, overflow=1; the 9th byte is never sent. Write STATUS bit3=1 -> overflow=0.
- Decode and strobe:
  - read at BASE_ADDR+0x20 -> read_data_o=0.
  - TXDATA write with strobe=4'b0010 -> no push.
  - DIVISOR write 0xBEEF with strobe=4'b0001 from 0x0363 -> reads 0x03EF.
- Parity (macro defined): CTRL=0x5 with DIV=1, TXDATA=0x07 -> parity bit 1 after the data bits, frame 22 cycles; with CTRL=0xD -> parity bit 0.
